// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution front-end.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, STREAM, PAD, GAP, FIN} feeder_state_t;
  localparam int DATA_WIDTH_DEF = 16;
  function automatic int pad_len(input int kernel_size);
    return kernel_size - 1;
  endfunction
endpackage

// File: rtl/sample_ram.sv
// sample_ram: frame buffer with one synchronous write and one synchronous read port.
module sample_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_frame_feeder.sv
// conv_frame_feeder: streams a buffered frame plus KERNEL_SIZE-1 zero pads into the convolution.
module conv_frame_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FRAME_LEN   = 256,
  parameter int KERNEL_SIZE = 5,
  parameter int GAP_CYCLES  = 0,
  parameter int ADDR_WIDTH  = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic                  x_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);
  localparam int PAD_N = pad_len(KERNEL_SIZE);
  localparam int PW = $clog2(KERNEL_SIZE + 1) > 0 ? $clog2(KERNEL_SIZE + 1) : 1;
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PAD_LAST = PW'(PAD_N > 0 ? PAD_N - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  feeder_state_t state, nxt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [PW-1:0] pad_cnt;
  logic [GW-1:0] gap_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic in_pad, zero_q, kill, go, wr_ok, emit, last_s, last_p;
  assign kill   = abort && busy;
  assign go     = start && !busy;
  assign wr_ok  = wr_en && !busy && (32'(wr_addr) < FRAME_LEN);
  assign last_s = idx == LAST;
  assign last_p = pad_cnt == PAD_LAST;
  // RAM read register holds the sample; zero_q masks it for pads, reset, done and abort
  assign x_out  = zero_q ? '0 : rd_data;
  sample_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FRAME_LEN), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk), .we(wr_ok), .waddr(wr_addr), .wdata(wr_data),
    .re(state == STREAM), .raddr(idx), .rdata(rd_data)
  );
  always_comb begin
    nxt  = state;
    emit = 1'b0;
    unique case (state)
      IDLE:   nxt = go ? STREAM : IDLE;
      STREAM: begin
        emit = 1'b1;
        nxt  = (last_s && PAD_N == 0) ? FIN : (GAP_CYCLES > 0) ? GAP : last_s ? PAD : STREAM;
      end
      GAP:    nxt = (gap_cnt != GAP_LAST) ? GAP : in_pad ? PAD : STREAM;
      PAD:    begin
        emit = 1'b1;
        nxt  = last_p ? FIN : (GAP_CYCLES > 0) ? GAP : PAD;
      end
      FIN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      pad_cnt <= '0;
      gap_cnt <= '0;
      in_pad  <= 1'b0;
      zero_q  <= 1'b1;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= nxt;
      x_valid <= emit && !kill;
      busy    <= (nxt != IDLE) || (state == FIN && !kill);
      done    <= state == FIN && !kill;
      cmd_err <= busy && !abort && (start || wr_en);
      zero_q  <= (kill || done) ? 1'b1 : emit ? (state == PAD) : zero_q;
      idx     <= go ? '0 : (state == STREAM && !last_s) ? idx + 1'b1 : idx;
      pad_cnt <= go ? '0 : (state == PAD) ? pad_cnt + 1'b1 : pad_cnt;
      gap_cnt <= (state == GAP && gap_cnt != GAP_LAST) ? gap_cnt + 1'b1 : '0;
      in_pad  <= go ? 1'b0 : (state == STREAM && last_s) ? 1'b1 : in_pad;
    end
  end
endmodule

// File: tb/tb_conv_frame_feeder.sv
// tb_conv_frame_feeder: directed/random frames on gap-0 and gap-2 feeders against a timing-formula model.
module tb_conv_frame_feeder;
  localparam int FL = 8, K = 5, DW = 16, AW = 3;
  localparam int GAPS [2] = '{0, 2};
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] xo [2];
  logic xv [2], bz [2], dn [2], ce [2];
  logic [DW-1:0] mb [FL];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  conv_frame_feeder #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .KERNEL_SIZE(K), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .x_out(xo[0]), .x_valid(xv[0]), .busy(bz[0]),
    .done(dn[0]), .cmd_err(ce[0])
  );
  conv_frame_feeder #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .KERNEL_SIZE(K), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .x_out(xo[1]), .x_valid(xv[1]), .busy(bz[1]),
    .done(dn[1]), .cmd_err(ce[1])
  );
  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s gap%0d: observed %0h expected %0h", tag, GAPS[i], obs, exp);
  endtask
  // Frame started in cycle 0: sample k valid at 2+k*(gap+1), done one cycle after the last sample.
  function automatic void model(input int i, input int c, input int ab,
                                output logic v, output logic b, output logic d, output logic [DW-1:0] x);
    int p = GAPS[i] + 1;
    int n = FL + K - 1;
    int l = 2 + (n - 1) * p;
    int dd = l + 1;
    bit alive = (ab < 0) || (c <= ab);
    int k = (c - 2) / p;
    if (k > n - 1) k = n - 1;
    v = alive && c >= 2 && c <= l && ((c - 2) % p == 0);
    b = alive && c >= 1 && c <= dd;
    d = (c == dd) && (ab < 0 || ab >= dd);
    x = (!alive || c < 2 || c > dd || k >= FL) ? '0 : mb[k];
  endfunction
  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, " x_out"}, i, xo[i], 0);
      chk({tag, " x_valid"}, i, xv[i], 0);
      chk({tag, " busy"}, i, bz[i], 0);
      chk({tag, " done"}, i, dn[i], 0);
      chk({tag, " cmd_err"}, i, ce[i], 0);
    end
  endtask
  task automatic run_frame(input int ncyc, input int ab, input int wr_c, input int st_c,
                           input bit w0, input logic [DW-1:0] w0d, input bit ia);
    logic v, b, d, pv, pb, pd;
    logic [DW-1:0] x, px;
    bit cmd_p;
    for (int c = 0; c < ncyc; c++) begin
      cmd_p = (c > 0) && ((c - 1) == wr_c || ((c - 1) == st_c && st_c > 0));
      for (int i = 0; i < 2; i++) begin
        model(i, c, ab, v, b, d, x);
        model(i, c - 1, ab, pv, pb, pd, px);
        chk($sformatf("x_valid c%0d", c), i, xv[i], v);
        chk($sformatf("x_out c%0d", c), i, xo[i], x);
        chk($sformatf("busy c%0d", c), i, bz[i], b);
        chk($sformatf("done c%0d", c), i, dn[i], d);
        chk($sformatf("cmd_err c%0d", c), i, ce[i], cmd_p && pb && (c - 1) != ab);
      end
      start   = (c == 0) || (c == st_c);
      wr_en   = (c == wr_c) || (c == 0 && w0);
      wr_addr = (c == 0) ? AW'(0) : AW'(3);
      wr_data = (c == 0) ? w0d : 16'h7fff;
      abort   = (c == ab) || (c == 0 && ia);
      if (c == 0 && w0) mb[0] = w0d;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wr_en = 1'b0;
    abort = 1'b0;
  endtask
  task automatic load_buffer();
    for (int a = 0; a < FL; a++) begin
      mb[a]   = DW'($urandom);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = mb[a];
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ab, wc;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    load_buffer();
    run_frame(39, -1, 4, 6, 1'b1, DW'($urandom), 1'b0);
    run_frame(8, 5, -1, -1, 1'b0, '0, 1'b0);
    run_frame(39, -1, -1, -1, 1'b0, '0, 1'b1);
    load_buffer();
    ab = $urandom_range(3, 30);
    wc = $urandom_range(1, ab - 1);
    run_frame(ab + 3, ab, wc, wc, 1'b0, '0, 1'b0);
    run_frame(11, -1, -1, -1, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(39, -1, -1, -1, 1'b0, '0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/conv_frame_feeder.md
Name: conv_frame_feeder

Overview:
Frame-buffered source that drives the streaming sample input of the temporal convolution stage. A host or upstream loader writes one frame of FRAME_LEN signed samples into an internal buffer. On a start pulse the block emits the frame as an x_out/x_valid stream, with a programmable idle gap between samples. It then appends KERNEL_SIZE-1 zero samples so the convolution tail drains, and signals completion.

Parameters:
DATA_WIDTH, 16, width of signed samples; matches the convolution's DATA_WIDTH.
FRAME_LEN, 256, samples per frame; must be at least 1.
KERNEL_SIZE, 5, taps of the downstream convolution; pad length is KERNEL_SIZE-1; must be at least 1.
GAP_CYCLES, 0, idle cycles (x_valid=0) inserted after every emitted sample, including pad samples.
ADDR_WIDTH, $clog2(FRAME_LEN) (minimum 1), buffer address width.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_n  in  1  reset, asynchronous, active-low.
wr_en  in  1  buffer write strobe.
wr_addr  in  ADDR_WIDTH  write address; wr_addr >= FRAME_LEN is ignored.
wr_data  in  DATA_WIDTH  signed sample to write.
start  in  1  begin streaming; single-cycle pulse.
abort  in  1  synchronous abort of the current frame.
x_out  out  DATA_WIDTH  signed sample to the convolution's x_in.
x_valid  out  1  qualifies x_out; drives the convolution's x_valid.
busy  out  1  frame in progress.
done  out  1  one-cycle pulse after the last pad sample.
cmd_err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (rst_n low, asynchronous): x_out=0, x_valid=0, busy=0, done=0, cmd_err=0, FSM=IDLE, all counters 0. Buffer contents are not reset.
- Buffer: single write port, synchronous read with 1-cycle latency. A write and a read to the same address in the same cycle returns the old data.
- FSM states: IDLE, STREAM, PAD, GAP, FIN.
- IDLE:
  - start=1 at edge E0 moves to STREAM and sets read address 0.
  - A write in the same cycle as start commits at E0 and is visible to the first read.
- STREAM:
  - Read data is registered to x_out with x_valid=1 for one cycle per sample.
  - With start in cycle 0, the first x_valid is in cycle 2 (2-cycle start latency).
  - After each sample, if GAP_CYCLES>0, go to GAP for exactly GAP_CYCLES cycles, then resume.
  - After sample FRAME_LEN-1, go to PAD.
- PAD: emit KERNEL_SIZE-1 samples with x_out=0 and x_valid=1, gap rules as in STREAM. If KERNEL_SIZE=1, PAD is skipped.
- FIN: done=1 for one cycle, then IDLE.
- busy: 1 from the cycle after start is accepted through the done cycle inclusive.
- x_out: holds its last value when x_valid=0, except it returns to 0 after done or abort.
- Writes while busy=1: ignored (buffer unchanged), cmd_err pulses for one cycle.
- start while busy=1: ignored, cmd_err pulses.
- start and wr_en both while busy: a single cmd_err pulse.
- abort=1 while busy:
  - Next edge goes to IDLE with x_valid=0, busy=0, and no done.
  - abort has priority over all other events in that cycle.
  - abort in IDLE has no effect.
- Counters: sample index (ADDR_WIDTH bits) stops at FRAME_LEN-1 without wrapping. The pad counter and gap counter are each $clog2(KERNEL_SIZE+1) and $clog2(GAP_CYCLES+1) bits, minimum 1.
- Throughput with GAP_CYCLES=0: one sample per cycle. A frame occupies FRAME_LEN+KERNEL_SIZE-1 valid cycles.

Decomposition:
- Package conv_pkg:
  - feeder_state_t enum (IDLE, STREAM, PAD, GAP, FIN).
  - Shared DATA_WIDTH default constant.
  - Function pad_len(KERNEL_SIZE), which returns KERNEL_SIZE-1.
- Sub-module sample_ram: DATA_WIDTH x FRAME_LEN buffer, one synchronous write and one synchronous read port, no reset.
- FSM, counters and output registers stay in conv_frame_feeder.

Test Plan:
1. FRAME_LEN=8, KERNEL_SIZE=5, GAP_CYCLES=0, buffer=1..8, start in cycle 0 -> x_valid=1 in cycles 2..13. x_out is 1..8 in cycles 2..9 and 0 in cycles 10..13. done in cycle 14; busy=1 in cycles 1..14.
2. Same frame, GAP_CYCLES=2 -> x_valid in cycles 2,5,8,...,35 (12 pulses, values 1..8 then four 0s). done in cycle 36.
3. Illegal commands: wr_en to address 3 with data 0x7FFF in cycle 4 of a frame -> cmd_err=1 in cycle 5, buffer[3] unchanged, stream unaffected. A start pulse in cycle 6 -> cmd_err=1 in cycle 7, frame not restarted.
4. abort in cycle 5 of test 1 -> x_valid=0 and busy=0 from cycle 6, no done. A new start in cycle 8 -> x_out=1 valid in cycle 10.
5. rst_n low mid-PAD -> all outputs 0 immediately (asynchronously). After release, start replays the intact buffer.
6. End-to-end with temporal_conv: COEFFS={1,0,0,0,0}, buffer=-5,3,... -> y_out reproduces the frame, 2 cycles behind x_valid. Pad zeros flush y_out to 0 with exactly FRAME_LEN+4 y_valid pulses.
